// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS core: word width, memory opcodes and data-memory FSM states.
package mips16_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [3:0] OP_LW = 4'b0101;
  localparam logic [3:0] OP_SW = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed 16-bit RAM: synchronous write, combinational read, contents not reset.
module dmem_array
  import mips16_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for LW/SW with req/ack handshake and configurable wait states.
// Optional alignment/range error check enabled by macro DMEM_ALIGN_CHECK_EN.
module data_mem_responder
  import mips16_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ack,
  output logic [WORD_W-1:0] rdata,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  dmem_state_t state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  capture_c;
  logic                  resp_c;
  logic                  busy_nxt;
  logic                  bad_c;
  logic                  cap_we;
  logic                  cap_bad;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [WORD_W-1:0]     cap_wdata;
  logic [WORD_W-1:0]     mem_rd;

`ifdef DMEM_ALIGN_CHECK_EN
  assign bad_c = addr[0] | (|addr[WORD_W-1:DEPTH_LOG2+1]);
`else
  // Byte-offset and out-of-range bits simply alias onto the array.
  logic unused_addr;
  assign unused_addr = ^{addr[0], addr[WORD_W-1:DEPTH_LOG2+1]};
  assign bad_c       = 1'b0;
`endif

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          capture_c = 1'b1;
          state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_c   = (state == RESP);
  assign busy_nxt = capture_c | (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= resp_c;
      busy  <= busy_nxt;
      if (resp_c && !cap_we) rdata <= cap_bad ? '0 : mem_rd;
    end
  end

  // Request is frozen at capture so the core may change addr/req during the wait.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_we    <= 1'b0;
      cap_bad   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (capture_c) begin
      cap_we    <= we;
      cap_bad   <= bad_c;
      cap_idx   <= addr[DEPTH_LOG2:1];
      cap_wdata <= wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= resp_c & cap_bad;
  end
`else
  assign err = 1'b0;
`endif

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clock (clock),
    .we    (resp_c & cap_we & ~cap_bad),
    .idx   (cap_idx),
    .wdata (cap_wdata),
    .rdata (mem_rd)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with WAIT_STATES 1, 0 and 3.
// Expectations follow DMEM_ALIGN_CHECK_EN when the macro is defined for the build.
module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req   [3];
  logic        we    [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic        ack   [3];
  logic [15:0] rdata [3];
  logic        busy  [3];
  logic        err   [3];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]), .err(err[0]));

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]), .err(err[1]));

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(3)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .busy(busy[2]), .err(err[2]));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One handshake on instance u; hold keeps req high after ack for a back-to-back request.
  task automatic access(input int u, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic hold, input int ws, input logic [15:0] exp_rd,
                        input logic exp_err, input string tag);
    int   n;
    logic seen;
    @(negedge clock);
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
    @(posedge clock); #1;
    check({tag, ".busy_cap"}, 16'(busy[u]), 16'h1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (ack[u]) seen = 1'b1;
      else check({tag, ".busy_wait"}, 16'(busy[u]), 16'h1);
    end
    check({tag, ".ack_seen"}, 16'(seen), 16'h1);
    check({tag, ".latency"}, 16'(n), 16'(ws + 1));
    check({tag, ".busy_ack"}, 16'(busy[u]), 16'h1);
    check({tag, ".rdata"}, rdata[u], exp_rd);
    check({tag, ".err"}, 16'(err[u]), 16'(exp_err));
    if (!hold) begin
      req[u] = 1'b0;
      @(posedge clock); #1;
      check({tag, ".ack_drop"}, 16'(ack[u]), 16'h0);
      check({tag, ".busy_drop"}, 16'(busy[u]), 16'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    #1 reset_n = 1'b0;
    #20;
    for (int i = 0; i < 3; i++) begin
      check("rst.ack",   16'(ack[i]),  16'h0);
      check("rst.busy",  16'(busy[i]), 16'h0);
      check("rst.err",   16'(err[i]),  16'h0);
      check("rst.rdata", rdata[i],     16'h0000);
    end
    @(negedge clock) reset_n = 1'b1;

    // Basic writes then reads, one wait state.
    access(0, 1'b1, 16'h0000, 16'h000F, 1'b0, 1, 16'h0000, 1'b0, "t1.wr0");
    access(0, 1'b1, 16'h0002, 16'h0007, 1'b0, 1, 16'h0000, 1'b0, "t1.wr2");
    access(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1, 16'h000F, 1'b0, "t1.rd0");
    access(0, 1'b0, 16'h0002, 16'h0000, 1'b0, 1, 16'h0007, 1'b0, "t1.rd2");

    // rdata survives a write; read-after-write sees the new word.
    access(0, 1'b1, 16'h0008, 16'h9999, 1'b0, 1, 16'h0007, 1'b0, "t6.wr8");
    access(0, 1'b0, 16'h0008, 16'h0000, 1'b0, 1, 16'h9999, 1'b0, "t6.rd8");

    // Zero wait states, back-to-back with req held through the write ack.
    access(1, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 0, 16'h0000, 1'b0, "t2.wr");
    access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 0, 16'hBEEF, 1'b0, "t2.rd");

    // Upper address bits alias onto the array unless the range check is on.
    access(1, 1'b1, 16'h0004, 16'h1234, 1'b0, 0, 16'hBEEF, 1'b0, "t3.wr");
`ifdef DMEM_ALIGN_CHECK_EN
    access(1, 1'b0, 16'h0204, 16'h0000, 1'b0, 0, 16'h0000, 1'b1, "t3.rd_bad");
    access(0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1, 16'h0000, 1'b1, "t4.rd_odd");
    access(0, 1'b1, 16'h0201, 16'hAAAA, 1'b0, 1, 16'h0000, 1'b1, "t4.wr_bad");
    access(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1, 16'h000F, 1'b0, "t4.rd0");
`else
    access(1, 1'b0, 16'h0204, 16'h0000, 1'b0, 0, 16'h1234, 1'b0, "t3.rd_alias");
    access(0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1, 16'h0007, 1'b0, "t3.rd_odd");
`endif

    // Reset in the middle of a three-wait-state write must abort it.
    access(2, 1'b1, 16'h0006, 16'h1111, 1'b0, 3, 16'h0000, 1'b0, "t5.wr_prior");
    access(2, 1'b0, 16'h0006, 16'h0000, 1'b0, 3, 16'h1111, 1'b0, "t5.rd_prior");
    @(negedge clock);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0006; wdata[2] = 16'h5555;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("t5.ack_rst",   16'(ack[2]),  16'h0);
    check("t5.busy_rst",  16'(busy[2]), 16'h0);
    check("t5.rdata_rst", rdata[2],     16'h0000);
    req[2] = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("t5.no_ack", 16'(ack[2]), 16'h0);
    end
    access(2, 1'b0, 16'h0006, 16'h0000, 1'b0, 3, 16'h1111, 1'b0, "t5.rd_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
